// File: rtl/ksenios_pkg.sv
// Shared definitions for the MII nibble hex-dump path: FSM states, ASCII
// framing characters and the MII preamble/SFD nibble values.
package ksenios_pkg;

   typedef enum logic [3:0] {
      HUNT     = 4'd0,
      SFD      = 4'd1,
      LO       = 4'd2,
      HI       = 4'd3,
      EMIT_H   = 4'd4,
      EMIT_L   = 4'd5,
      EMIT_SEP = 4'd6,
      EMIT_CR  = 4'd7,
      EMIT_LF  = 4'd8
   } state_e;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;

   localparam logic [3:0] NIB_PREAMBLE = 4'h5;
   localparam logic [3:0] NIB_SFD      = 4'hD;

endpackage

// File: rtl/bin2ascii.sv
// Converts one binary nibble into its upper-case ASCII hex digit.
module bin2ascii (
   input  logic [3:0] bin_i,
   output logic [7:0] ascii_o
);

   // 'A' - 10 = 0x37, so letters and digits share one adder.
   assign ascii_o = (bin_i < 4'd10) ? {4'h3, bin_i} : (8'h37 + {4'h0, bin_i});

endmodule

// File: rtl/mii_hexdump.sv
// Pairs MII receive nibbles into bytes and prints them to the UART as hex
// text, with CR LF line breaks and per-frame / per-byte counters.
module mii_hexdump
   import ksenios_pkg::*;
#(
   parameter int unsigned BYTES_PER_LINE = 16,
   parameter bit          STRIP_PREAMBLE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        nib_empty,
   input  logic [3:0]  nib_data,
   input  logic        nib_last,
   output logic        nib_rd,
   input  logic        tx_full,
   output logic        wr_uart,
   output logic [7:0]  w_data,
   output logic [15:0] frame_count,
   output logic [15:0] byte_count
);

   localparam state_e     START_STATE = state_e'(STRIP_PREAMBLE ? HUNT : LO);
   localparam logic [7:0] LAST_COL    = 8'(BYTES_PER_LINE - 1);

   state_e      state_q, state_d;
   logic [3:0]  lo_q, lo_d;
   logic [3:0]  hi_q, hi_d;
   logic        last_q, last_d;
   logic        odd_q, odd_d;
   logic        first_q, first_d;
   logic        hold_q;
   logic [7:0]  column_q, column_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] bytes_q, bytes_d;

   logic [3:0]  hex_sel;
   logic [7:0]  hex_char;
   logic [7:0]  char_d;
   logic        blocked;
   logic        pop_ok;
   logic        wr_ok;
   logic        frame_end;

   assign hex_sel = (state_q == EMIT_H) ? hi_q : lo_q;

   bin2ascii u_bin2ascii (
      .bin_i   (hex_sel),
      .ascii_o (hex_char)
   );

   // Handshakes stay quiet during reset and for one cycle after it.
   assign blocked   = reset | hold_q;
   assign pop_ok    = ~nib_empty & ~blocked;
   assign wr_ok     = ~tx_full & ~blocked;
   assign frame_end = last_q | odd_q;

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      last_d   = last_q;
      odd_d    = odd_q;
      first_d  = first_q;
      column_d = column_q;
      frame_d  = frame_q;
      bytes_d  = bytes_q;
      char_d   = 8'h00;
      nib_rd   = 1'b0;
      wr_uart  = 1'b0;

      case (state_q)
         HUNT: begin
            if (pop_ok) begin
               nib_rd = 1'b1;
               if (!nib_last && nib_data == NIB_PREAMBLE) begin
                  state_d = SFD;
               end
            end
         end

         SFD: begin
            if (pop_ok) begin
               nib_rd = 1'b1;
               if (nib_last) begin
                  state_d = HUNT;
               end else if (nib_data == NIB_SFD) begin
                  state_d = LO;
                  bytes_d = 16'd0;
               end else if (nib_data != NIB_PREAMBLE) begin
                  state_d = HUNT;
               end
            end
         end

         LO: begin
            if (pop_ok) begin
               nib_rd = 1'b1;
               lo_d   = nib_data;
               // Without preamble stripping the first data nibble marks frame start.
               if (!STRIP_PREAMBLE && first_q) begin
                  bytes_d = 16'd0;
                  first_d = 1'b0;
               end
               if (nib_last) begin
                  odd_d   = 1'b1;
                  state_d = EMIT_L;
               end else begin
                  state_d = HI;
               end
            end
         end

         HI: begin
            if (pop_ok) begin
               nib_rd  = 1'b1;
               hi_d    = nib_data;
               last_d  = nib_last;
               bytes_d = bytes_q + 16'd1;
               state_d = EMIT_H;
            end
         end

         EMIT_H: begin
            char_d = hex_char;
            if (wr_ok) begin
               wr_uart = 1'b1;
               state_d = EMIT_L;
            end
         end

         EMIT_L: begin
            char_d = hex_char;
            if (wr_ok) begin
               wr_uart = 1'b1;
               if (frame_end || column_q == LAST_COL) begin
                  state_d = EMIT_CR;
               end else begin
                  state_d = EMIT_SEP;
               end
            end
         end

         EMIT_SEP: begin
            char_d = SPACE;
            if (wr_ok) begin
               wr_uart  = 1'b1;
               column_d = column_q + 8'd1;
               state_d  = LO;
            end
         end

         EMIT_CR: begin
            char_d = CR;
            if (wr_ok) begin
               wr_uart = 1'b1;
               state_d = EMIT_LF;
            end
         end

         EMIT_LF: begin
            char_d = LF;
            if (wr_ok) begin
               wr_uart  = 1'b1;
               column_d = 8'd0;
               if (frame_end) begin
                  frame_d = frame_q + 16'd1;
                  last_d  = 1'b0;
                  odd_d   = 1'b0;
                  first_d = 1'b1;
                  state_d = START_STATE;
               end else begin
                  state_d = LO;
               end
            end
         end

         default: state_d = START_STATE;
      endcase

      w_data = wr_uart ? char_d : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= START_STATE;
         last_q   <= 1'b0;
         odd_q    <= 1'b0;
         first_q  <= 1'b1;
         column_q <= 8'd0;
         frame_q  <= 16'd0;
         bytes_q  <= 16'd0;
         hold_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         odd_q    <= odd_d;
         first_q  <= first_d;
         column_q <= column_d;
         frame_q  <= frame_d;
         bytes_q  <= bytes_d;
         hold_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      lo_q <= lo_d;
      hi_q <= hi_d;
   end

   assign frame_count = frame_q;
   assign byte_count  = bytes_q;

endmodule

// File: tb/tb_mii_hexdump.sv
// Bench for mii_hexdump: two instances (16 and 2 bytes per line) fed from
// queue-modelled nibble FIFOs and compared against a text-level reference.
module tb_mii_hexdump;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        tx_full;

   logic        e0, l0, rd0, wu0;
   logic [3:0]  d0;
   logic [7:0]  wd0;
   logic [15:0] fc0, bc0;

   logic        e1, l1, rd1, wu1;
   logic [3:0]  d1;
   logic [7:0]  wd1;
   logic [15:0] fc1, bc1;

   mii_hexdump #(.BYTES_PER_LINE(16), .STRIP_PREAMBLE(1'b1)) u_dut16 (
      .clk(clk), .reset(reset), .nib_empty(e0), .nib_data(d0), .nib_last(l0),
      .nib_rd(rd0), .tx_full(tx_full), .wr_uart(wu0), .w_data(wd0),
      .frame_count(fc0), .byte_count(bc0)
   );

   mii_hexdump #(.BYTES_PER_LINE(2), .STRIP_PREAMBLE(1'b1)) u_dut2 (
      .clk(clk), .reset(reset), .nib_empty(e1), .nib_data(d1), .nib_last(l1),
      .nib_rd(rd1), .tx_full(tx_full), .wr_uart(wu1), .w_data(wd1),
      .frame_count(fc1), .byte_count(bc1)
   );

   int passed = 0;
   int total  = 0;

   logic [4:0] nq0[$];
   logic [4:0] nq1[$];
   logic [7:0] got0[$];
   logic [7:0] got1[$];
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   logic [3:0] pay[$];

   bit rand_bp   = 1'b0;
   bit stall_mon = 1'b0;
   bit gap0      = 1'b0;
   bit gap1      = 1'b0;
   int stall_viol;
   int efc = 0;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      string h;
      h = "0123456789ABCDEF";
      return h[n];
   endfunction

   task automatic drive();
      logic [4:0] t0, t1;
      t0 = (nq0.size() > 0) ? nq0[0] : 5'd0;
      t1 = (nq1.size() > 0) ? nq1[0] : 5'd0;
      e0 = (nq0.size() == 0) || gap0;
      d0 = t0[3:0];
      l0 = t0[4];
      e1 = (nq1.size() == 0) || gap1;
      d1 = t1[3:0];
      l1 = t1[4];
   endtask

   // Observe at the falling edge, then advance the FIFO models after the rising edge.
   task automatic cycle();
      logic r0, r1;
      @(negedge clk);
      r0 = rd0;
      r1 = rd1;
      if (wu0) got0.push_back(wd0);
      if (wu1) got1.push_back(wd1);
      if (stall_mon && (rd0 || wu0 || rd1 || wu1)) stall_viol++;
      @(posedge clk);
      #1;
      if (r0 && nq0.size() > 0) void'(nq0.pop_front());
      if (r1 && nq1.size() > 0) void'(nq1.pop_front());
      if (rand_bp) begin
         tx_full = ($urandom_range(0, 3) == 0);
         gap0    = ($urandom_range(0, 4) == 0);
         gap1    = ($urandom_range(0, 4) == 0);
      end
      drive();
   endtask

   // Expected text: items are full bytes (hi digit then lo digit) and an
   // optional trailing lone nibble; space between items, CR LF after every
   // bpl items and exactly once after the final item.
   task automatic build_exp();
      logic [7:0] t[$];
      int nb, items, bpl;
      nb    = pay.size() / 2;
      items = nb + (pay.size() % 2);
      for (int w = 0; w < 2; w++) begin
         bpl = (w == 0) ? 16 : 2;
         t.delete();
         for (int k = 0; k < items; k++) begin
            if (k < nb) begin
               t.push_back(hexc(pay[2*k+1]));
               t.push_back(hexc(pay[2*k]));
            end else begin
               t.push_back(hexc(pay[2*k]));
            end
            if (k == items - 1 || ((k + 1) % bpl) == 0) begin
               t.push_back(8'h0D);
               t.push_back(8'h0A);
            end else begin
               t.push_back(8'h20);
            end
         end
         if (w == 0) exp0 = t;
         else        exp1 = t;
      end
   endtask

   task automatic start_frame(input int junk, input int pre);
      logic [4:0] s[$];
      int v;
      for (int i = 0; i < junk; i++) begin
         v = $urandom_range(0, 14);
         if (v >= 5) v++;
         s.push_back({1'b0, 4'(v)});
      end
      for (int i = 0; i < pre; i++) s.push_back({1'b0, 4'h5});
      s.push_back({1'b0, 4'hD});
      for (int i = 0; i < pay.size(); i++) s.push_back({(i == pay.size() - 1), pay[i]});
      foreach (s[i]) begin
         nq0.push_back(s[i]);
         nq1.push_back(s[i]);
      end
      got0.delete();
      got1.delete();
      build_exp();
      drive();
   endtask

   task automatic finish_frame(input string tag);
      int n, m0, m1;
      n = 0;
      while (!(nq0.size() == 0 && nq1.size() == 0 &&
               got0.size() >= exp0.size() && got1.size() >= exp1.size()) && n < 4000) begin
         cycle();
         n++;
      end
      chk({tag, "_done"}, int'(n < 4000), 1);
      repeat (4) cycle();
      efc++;
      m0 = 0;
      m1 = 0;
      for (int k = 0; k < got0.size() && k < exp0.size(); k++) if (got0[k] !== exp0[k]) m0++;
      for (int k = 0; k < got1.size() && k < exp1.size(); k++) if (got1[k] !== exp1[k]) m1++;
      chk({tag, "_len16"}, got0.size(), exp0.size());
      chk({tag, "_text16"}, m0, 0);
      chk({tag, "_len2"}, got1.size(), exp1.size());
      chk({tag, "_text2"}, m1, 0);
      chk({tag, "_fc16"}, int'(fc0), efc & 16'hFFFF);
      chk({tag, "_bc16"}, int'(bc0), pay.size() / 2);
      chk({tag, "_fc2"}, int'(fc1), efc & 16'hFFFF);
      chk({tag, "_bc2"}, int'(bc1), pay.size() / 2);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd16"}, int'(rd0), 0);
      chk({tag, "_wr16"}, int'(wu0), 0);
      chk({tag, "_wd16"}, int'(wd0), 0);
      chk({tag, "_fc16"}, int'(fc0), 0);
      chk({tag, "_bc16"}, int'(bc0), 0);
      chk({tag, "_rd2"}, int'(rd1), 0);
      chk({tag, "_wr2"}, int'(wu1), 0);
      chk({tag, "_fc2"}, int'(fc1), 0);
      chk({tag, "_bc2"}, int'(bc1), 0);
   endtask

   initial begin
      int n, len;
      reset   = 1'b1;
      tx_full = 1'b0;

      // Reset with a frame already waiting in the FIFO.
      pay = '{4'h5, 4'h5};
      start_frame(0, 15);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_idle("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_idle("post_reset");
      @(posedge clk);
      #1;
      finish_frame("b55");

      pay = '{4'h1, 4'hA, 4'hF, 4'h3};
      start_frame(2, 7);
      finish_frame("a13f");
      chk("a13f_writes", got0.size(), 7);

      pay = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
      start_frame(0, 4);
      finish_frame("three");

      pay = '{4'h2, 4'h1, 4'h7};
      start_frame(1, 6);
      finish_frame("odd");

      // Back-pressure for 20 cycles just after the first hex digit.
      pay = '{4'h4, 4'hC, 4'hB, 4'h9, 4'hE, 4'h5};
      start_frame(0, 8);
      n = 0;
      while (got0.size() < 1 && n < 500) begin
         cycle();
         n++;
      end
      chk("stall_reach", int'(n < 500), 1);
      tx_full    = 1'b1;
      stall_viol = 0;
      stall_mon  = 1'b1;
      repeat (20) cycle();
      stall_mon = 1'b0;
      tx_full   = 1'b0;
      chk("stall_quiet", stall_viol, 0);
      chk("stall_hold16", got0.size(), 1);
      finish_frame("stall");

      rand_bp = 1'b1;
      for (int f = 0; f < 10; f++) begin
         pay.delete();
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) pay.push_back(4'($urandom_range(0, 15)));
         start_frame($urandom_range(0, 3), $urandom_range(1, 15));
         finish_frame($sformatf("rnd%0d", f));
      end
      rand_bp = 1'b0;
      tx_full = 1'b0;
      gap0    = 1'b0;
      gap1    = 1'b0;
      drive();

      // Reset while the separator is being offered.
      pay = '{4'h1, 4'hA, 4'hF, 4'h3};
      start_frame(0, 3);
      n = 0;
      while (got0.size() < 2 && n < 500) begin
         cycle();
         n++;
      end
      chk("sep_reach", int'(n < 500), 1);
      chk("sep_wr", int'(wu0), 1);
      chk("sep_char", int'(wd0), 8'h20);
      reset = 1'b1;
      nq0.delete();
      nq1.delete();
      drive();
      @(negedge clk);
      chk("sep_rst_wr16", int'(wu0), 0);
      chk("sep_rst_wd16", int'(wd0), 0);
      chk("sep_rst_wr2", int'(wu1), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      efc   = 0;
      @(negedge clk);
      chk_idle("after_sep_rst");
      @(posedge clk);
      #1;
      pay = '{4'hF, 4'hF};
      start_frame(1, 7);
      finish_frame("ff");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
